// File: rtl/histo_readout_ctrl.sv
// histo_readout_ctrl
//   Frame-level sequencer between frame sync, the histogram2 accumulator and
//   the Serializer. Arms the histogram for accumulation on each frame sync,
//   waits for histo_done, then reads bins 0..NUM_BINS-1 out to the serializer
//   one word per ser_done. Counts completed readouts and flags overruns.
//
//   Optional feature macro: HISTO_FRAME_HEADER_EN
//     When defined, each readout is preceded by a header word
//     {8'hA5, frame_cnt[15:0]}. DATA_W must be 24 and FCNT_W 16 in that build.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   fsin                frame sync (rising edge used)
//   histo_done          accumulation complete (rising edge used)
//   histo_data          histogram read data for histo_bin
//   ser_done            serializer word complete (rising edge used)
//   ovr_clr             clears sticky overrun
//   histo_rw            1 = accumulate, 0 = read
//   histo_bin           bin address to histogram
//   ser_rst             1 = serializer hold/load, 0 = shift ser_data
//   ser_data            registered word to serializer
//   frame_cnt           completed readouts (wraps)
//   busy                high outside IDLE
//   overrun             sticky: frame sync arrived before readout finished
module histo_readout_ctrl #(
  parameter int unsigned NUM_BINS   = 1024,
  parameter int unsigned BIN_W      = 10,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned FCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fsin,
  input  logic              histo_done,
  input  logic [DATA_W-1:0] histo_data,
  input  logic              ser_done,
  input  logic              ovr_clr,
  output logic              histo_rw,
  output logic [BIN_W-1:0]  histo_bin,
  output logic              ser_rst,
  output logic [DATA_W-1:0] ser_data,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_SETTLE, S_SHIFT} state_t;

  state_t state, state_nx;

  // Each event input passes a synchroniser register then an edge register,
  // so an input sampled in cycle N affects the outputs in cycle N+2.
  logic fsin_s, fsin_q, hd_s, hd_q, sd_s, sd_q;
  logic fsin_rise, hd_rise, sd_rise;

  logic [3:0]        cnt, cnt_nx;
  logic [BIN_W-1:0]  bin_nx;
  logic [DATA_W-1:0] data_nx;
  logic [FCNT_W-1:0] fcnt_nx;
  logic              ovr_nx;
`ifdef HISTO_FRAME_HEADER_EN
  logic              hdr_pend, hdr_pend_nx;
`endif

  assign fsin_rise = fsin_s & ~fsin_q;
  assign hd_rise   = hd_s   & ~hd_q;
  assign sd_rise   = sd_s   & ~sd_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bin_nx   = histo_bin;
    data_nx  = ser_data;
    fcnt_nx  = frame_cnt;
    ovr_nx   = overrun;
`ifdef HISTO_FRAME_HEADER_EN
    hdr_pend_nx = hdr_pend;
`endif
    if (ovr_clr) ovr_nx = 1'b0;

    if (fsin_rise && state != S_IDLE) begin
      // Overrun: abort the frame and re-arm; set beats a concurrent clear.
      ovr_nx   = 1'b1;
      state_nx = S_ACQ;
      bin_nx   = '0;
`ifdef HISTO_FRAME_HEADER_EN
      hdr_pend_nx = 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (fsin_rise) state_nx = S_ACQ;
        S_ACQ: begin
          if (hd_rise) begin
            state_nx = S_SETTLE;
            bin_nx   = '0;
            cnt_nx   = 4'(SETTLE_CYC - 1);
`ifdef HISTO_FRAME_HEADER_EN
            hdr_pend_nx = 1'b1;
`endif
          end
        end
        S_SETTLE: begin
          if (cnt == 4'd0) begin
            state_nx = S_SHIFT;
`ifdef HISTO_FRAME_HEADER_EN
            data_nx = hdr_pend ? DATA_W'({8'hA5, frame_cnt[15:0]}) : histo_data;
`else
            data_nx = histo_data;
`endif
          end else begin
            cnt_nx = cnt - 4'd1;
          end
        end
        S_SHIFT: begin
          if (sd_rise) begin
`ifdef HISTO_FRAME_HEADER_EN
            if (hdr_pend) begin
              hdr_pend_nx = 1'b0;
              state_nx    = S_SETTLE;
              cnt_nx      = 4'(SETTLE_CYC - 1);
            end else
`endif
            if (histo_bin == BIN_W'(NUM_BINS - 1)) begin
              state_nx = S_IDLE;
              bin_nx   = '0;
              fcnt_nx  = frame_cnt + 1'b1;
            end else begin
              state_nx = S_SETTLE;
              bin_nx   = histo_bin + 1'b1;
              cnt_nx   = 4'(SETTLE_CYC - 1);
            end
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fsin_s    <= 1'b0;
      fsin_q    <= 1'b0;
      hd_s      <= 1'b0;
      hd_q      <= 1'b0;
      sd_s      <= 1'b0;
      sd_q      <= 1'b0;
      cnt       <= '0;
      histo_bin <= '0;
      ser_data  <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
      histo_rw  <= 1'b1;
      ser_rst   <= 1'b1;
      busy      <= 1'b0;
`ifdef HISTO_FRAME_HEADER_EN
      hdr_pend  <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      fsin_s    <= fsin;
      fsin_q    <= fsin_s;
      hd_s      <= histo_done;
      hd_q      <= hd_s;
      sd_s      <= ser_done;
      sd_q      <= sd_s;
      cnt       <= cnt_nx;
      histo_bin <= bin_nx;
      ser_data  <= data_nx;
      frame_cnt <= fcnt_nx;
      overrun   <= ovr_nx;
      // Outputs decoded from the next state so they are registered yet
      // change in the same cycle as the state itself.
      histo_rw  <= (state_nx == S_IDLE) || (state_nx == S_ACQ);
      ser_rst   <= (state_nx != S_SHIFT);
      busy      <= (state_nx != S_IDLE);
`ifdef HISTO_FRAME_HEADER_EN
      hdr_pend  <= hdr_pend_nx;
`endif
    end
  end

endmodule

// File: tb/tb_histo_readout_ctrl.sv
module tb_histo_readout_ctrl;

  localparam int unsigned NUM_BINS = 4;
  localparam int unsigned BIN_W    = 10;
  localparam int unsigned DATA_W   = 24;
  localparam int unsigned SETTLE   = 3;
  localparam int unsigned FCNT_W   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fsin = 1'b0, histo_done = 1'b0, ser_done = 1'b0, ovr_clr = 1'b0;
  logic [DATA_W-1:0] histo_data;
  logic              histo_rw, ser_rst, busy, overrun;
  logic [BIN_W-1:0]  histo_bin;
  logic [DATA_W-1:0] ser_data;
  logic [FCNT_W-1:0] frame_cnt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Histogram memory model: bin k holds k*3.
  assign histo_data = DATA_W'(histo_bin) * 24'd3;

  histo_readout_ctrl #(
    .NUM_BINS(NUM_BINS), .BIN_W(BIN_W), .DATA_W(DATA_W),
    .SETTLE_CYC(SETTLE), .FCNT_W(FCNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fsin(fsin), .histo_done(histo_done),
    .histo_data(histo_data), .ser_done(ser_done), .ovr_clr(ovr_clr),
    .histo_rw(histo_rw), .histo_bin(histo_bin), .ser_rst(ser_rst),
    .ser_data(ser_data), .frame_cnt(frame_cnt), .busy(busy), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Pulse histo_done (which=0) or ser_done (which=1) for one cycle N and
  // return the number of cycles until ser_rst is seen low, plus a snapshot
  // of bin/ser_rst/histo_rw at N+2.
  task automatic pulse_wait(input int which, output int n, output logic [31:0] bin2,
                            output logic rst2, output logic rw2);
    if (which == 0) histo_done = 1'b1; else ser_done = 1'b1;
    n = 0; bin2 = '1; rst2 = 1'bx; rw2 = 1'bx;
    while (n < 50) begin
      tick();
      n++;
      histo_done = 1'b0;
      ser_done   = 1'b0;
      if (n == 2) begin
        bin2 = 32'(histo_bin); rst2 = ser_rst; rw2 = histo_rw;
      end
      if (n >= 2 && !ser_rst) break;
    end
  endtask

  task automatic pulse_fsin();
    fsin = 1'b1;
    tick();
    fsin = 1'b0;
  endtask

  int          n;
  logic [31:0] b2;
  logic        r2, w2;

  initial begin
    // Reset state
    ticks(3);
    check("rst_histo_rw", 32'(histo_rw), 1);
    check("rst_bin", 32'(histo_bin), 0);
    check("rst_ser_rst", 32'(ser_rst), 1);
    check("rst_ser_data", 32'(ser_data), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    ticks(2);

    // Spurious ser_done in IDLE
    ser_done = 1'b1; tick(); ser_done = 1'b0; ticks(3);
    check("idle_spur_busy", 32'(busy), 0);
    check("idle_spur_bin", 32'(histo_bin), 0);

    // Frame sync: busy at N+2, not at N+1
    pulse_fsin();
    check("fsin_n1_busy", 32'(busy), 0);
    tick();
    check("fsin_n2_busy", 32'(busy), 1);
    check("fsin_n2_rw", 32'(histo_rw), 1);

    // Spurious ser_done in ACQ
    ser_done = 1'b1; tick(); ser_done = 1'b0; ticks(3);
    check("acq_spur_rw", 32'(histo_rw), 1);
    check("acq_spur_rst", 32'(ser_rst), 1);

    // Full frame
    pulse_wait(0, n, b2, r2, w2);
    check("hd_n2_rw", 32'(w2), 0);
    check("hd_n2_bin", b2, 0);
    check("hd_settle_cyc", 32'(n), 5);
    for (int k = 0; k < NUM_BINS; k++) begin
      check("word_data", 32'(ser_data), 32'(k * 3));
      ticks(4);
      if (k == 1) begin
        histo_done = 1'b1; tick(); histo_done = 1'b0; ticks(3);
        check("shift_spur_bin", 32'(histo_bin), 1);
        check("shift_spur_rst", 32'(ser_rst), 0);
        ticks(2);
      end else begin
        ticks(6);
      end
      check("word_stable", 32'(ser_data), 32'(k * 3));
      if (k < NUM_BINS - 1) begin
        pulse_wait(1, n, b2, r2, w2);
        check("sd_n2_bin", b2, 32'(k + 1));
        check("sd_n2_rst", 32'(r2), 1);
        check("sd_settle_cyc", 32'(n), 5);
      end else begin
        ser_done = 1'b1; tick(); ser_done = 1'b0; tick();
        check("end_frame_cnt", 32'(frame_cnt), 1);
        check("end_rw", 32'(histo_rw), 1);
        check("end_busy", 32'(busy), 0);
        check("end_bin", 32'(histo_bin), 0);
      end
    end
    ticks(3);

    // Overrun at bin 2
    pulse_fsin(); tick();
    pulse_wait(0, n, b2, r2, w2);
    for (int k = 0; k < 2; k++) begin
      ticks(10);
      pulse_wait(1, n, b2, r2, w2);
    end
    check("ovr_pre_bin", 32'(histo_bin), 2);
    check("ovr_pre_rst", 32'(ser_rst), 0);
    pulse_fsin(); tick();
    check("ovr_flag", 32'(overrun), 1);
    check("ovr_acq_rw", 32'(histo_rw), 1);
    check("ovr_bin", 32'(histo_bin), 0);
    check("ovr_rst", 32'(ser_rst), 1);
    check("ovr_frame_cnt", 32'(frame_cnt), 1);
    check("ovr_busy", 32'(busy), 1);
    // Second overrun in ACQ with ovr_clr in the event cycle: set wins
    ticks(2);
    fsin = 1'b1; tick(); fsin = 1'b0; ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    check("ovr_set_wins", 32'(overrun), 1);
    tick();
    check("ovr_set_hold", 32'(overrun), 1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 0);

    // Async reset mid-SHIFT (bin 1 so ser_data is non-zero)
    pulse_wait(0, n, b2, r2, w2);
    ticks(10);
    pulse_wait(1, n, b2, r2, w2);
    check("prerst_data", 32'(ser_data), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_rst", 32'(ser_rst), 1);
    check("arst_rw", 32'(histo_rw), 1);
    check("arst_bin", 32'(histo_bin), 0);
    check("arst_data", 32'(ser_data), 0);
    check("arst_fcnt", 32'(frame_cnt), 0);
    tick();
    rst_n = 1'b1;
    ticks(2);
    pulse_fsin(); tick();
    check("restart_busy", 32'(busy), 1);
    check("restart_rw", 32'(histo_rw), 1);
    check("restart_bin", 32'(histo_bin), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
